// File: rtl/redirect_flush_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_flush_ctrl
//
// Sequences pipeline recovery after the ROB retires a mispredicted branch/jalr.
// An accepted redirect produces the following sequence:
//   1. a one-cycle flush pulse to RAT (ARF/ROB + tag tables), ROB, IIQ, LSQ and
//      IFIFO;
//   2. the latched redirect PC, presented to fetch over a valid/ready handshake;
//   3. a wait for the LSU to drain, bounded by DRAIN_TIMEOUT cycles;
//   4. a settle window of SETTLE_CYCLES cycles.
// Dispatch stays stalled from acceptance until the FSM is back in IDLE.
//
// Parameters
//   SETTLE_CYCLES  stall cycles after drain, before dispatch resumes (>=1)
//   DRAIN_TIMEOUT  max cycles spent in DRAIN before a forced exit (>=1)
//   CNT_WIDTH      width of redirect_cnt
//
// Ports
//   clk                  in   rising-edge clock
//   rst_aL               in   asynchronous active-low reset
//   rob_redirect_valid   in   ROB retiring a mispredicted branch (1-cycle pulse)
//   rob_redirect_pc      in   correct next PC
//   lsu_busy             in   LSU has a load/store in flight
//   fetch_redirect_ready in   fetch accepts the redirect this cycle
//   flush                out  pipeline flush pulse
//   fetch_redirect_valid out  redirect PC valid to fetch
//   fetch_redirect_pc    out  latched redirect PC
//   dispatch_stall       out  blocks the dispatch handshake
//   state_o              out  current FSM state (debug)
//   redirect_cnt         out  accepted redirects, saturating
//   overlap_err          out  sticky: a redirect arrived while not IDLE
//   drain_timeout_err    out  sticky: DRAIN exited on timeout
//
// Every output is a decode of registered state, so none of them has a
// combinational path from an input.
// -----------------------------------------------------------------------------
module redirect_flush_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 rob_redirect_valid,
  input  logic [31:0]          rob_redirect_pc,
  input  logic                 lsu_busy,
  input  logic                 fetch_redirect_ready,
  output logic                 flush,
  output logic                 fetch_redirect_valid,
  output logic [31:0]          fetch_redirect_pc,
  output logic                 dispatch_stall,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] redirect_cnt,
  output logic                 overlap_err,
  output logic                 drain_timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    REDIR  = 3'd2,
    DRAIN  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  // DRAIN and SETTLE are never active together, so a single phase counter
  // serves both. It is cleared on entry to either state and counts up to
  // the last cycle of that state. It never wraps.
  localparam int CNT_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT
                                                           : SETTLE_CYCLES;
  localparam int PW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PW-1:0] DRAIN_LAST  = PW'(DRAIN_TIMEOUT - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   pc_q;
  logic          accept;       // redirect taken in IDLE this cycle
  logic          overlap;      // redirect seen outside IDLE, ignored
  logic          drain_expire; // DRAIN left because the timeout was reached

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so that no branch
    // can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    accept       = 1'b0;
    overlap      = 1'b0;
    drain_expire = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rob_redirect_valid) begin
          accept  = 1'b1;
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        state_d = REDIR;
      end

      REDIR: begin
        // Fetch may hold off indefinitely. The PC stays stable meanwhile
        // because it comes from pc_q.
        if (fetch_redirect_ready) begin
          phase_d = '0;
          state_d = lsu_busy ? DRAIN : SETTLE;
        end
      end

      DRAIN: begin
        if (!lsu_busy) begin
          phase_d = '0;
          state_d = SETTLE;
        end else if (phase_q == DRAIN_LAST) begin
          drain_expire = 1'b1;
          phase_d      = '0;
          state_d      = SETTLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      SETTLE: begin
        // The entry cycle counts as the first settle cycle.
        if (phase_q == SETTLE_LAST) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // A redirect is accepted only when the FSM is in IDLE at the sampling
    // edge. That includes the last SETTLE cycle, which drops the redirect.
    // The flush already issued kills whatever younger op retired.
    if (rob_redirect_valid && (state_q != IDLE)) begin
      overlap = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q           <= IDLE;
      phase_q           <= '0;
      pc_q              <= '0;
      redirect_cnt      <= '0;
      overlap_err       <= 1'b0;
      drain_timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;

      if (accept) begin
        pc_q <= rob_redirect_pc;
        if (redirect_cnt != '1) begin
          redirect_cnt <= redirect_cnt + 1'b1;
        end
      end

      // Sticky until reset.
      if (overlap) begin
        overlap_err <= 1'b1;
      end
      if (drain_expire) begin
        drain_timeout_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decodes
  // ---------------------------------------------------------------------------
  assign flush                = (state_q == FLUSH);
  assign fetch_redirect_valid = (state_q == REDIR);
  assign fetch_redirect_pc    = pc_q;
  assign dispatch_stall       = (state_q != IDLE);
  assign state_o              = state_q;

endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redirect_flush_ctrl
//
// Directed testbench for redirect_flush_ctrl.
//   dut      uses the default parameters (SETTLE=2, DRAIN_TIMEOUT=64, CNT=16).
//   dut_sat  uses CNT_WIDTH=2 and is used only for the saturation check.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, which is well clear of the active edge.
// -----------------------------------------------------------------------------
module tb_redirect_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        rob_redirect_valid;
  logic [31:0] rob_redirect_pc;
  logic        lsu_busy;
  logic        fetch_redirect_ready;

  logic        flush;
  logic        fetch_redirect_valid;
  logic [31:0] fetch_redirect_pc;
  logic        dispatch_stall;
  logic [2:0]  state_o;
  logic [15:0] redirect_cnt;
  logic        overlap_err;
  logic        drain_timeout_err;

  // Saturation instance signals.
  logic        s_rst_aL;
  logic        s_valid;
  logic        s_flush;
  logic        s_fvalid;
  logic [31:0] s_fpc;
  logic        s_stall;
  logic [2:0]  s_state;
  logic [1:0]  s_cnt;
  logic        s_ovl;
  logic        s_tmo;

  int n_cmp      = 0;
  int n_err      = 0;
  int flush_seen = 0;
  int flush_base = 0;
  int drain_cyc  = 0;

  always #5 clk = ~clk;

  redirect_flush_ctrl dut (
    .clk                  (clk),
    .rst_aL               (rst_aL),
    .rob_redirect_valid   (rob_redirect_valid),
    .rob_redirect_pc      (rob_redirect_pc),
    .lsu_busy             (lsu_busy),
    .fetch_redirect_ready (fetch_redirect_ready),
    .flush                (flush),
    .fetch_redirect_valid (fetch_redirect_valid),
    .fetch_redirect_pc    (fetch_redirect_pc),
    .dispatch_stall       (dispatch_stall),
    .state_o              (state_o),
    .redirect_cnt         (redirect_cnt),
    .overlap_err          (overlap_err),
    .drain_timeout_err    (drain_timeout_err)
  );

  redirect_flush_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk                  (clk),
    .rst_aL               (s_rst_aL),
    .rob_redirect_valid   (s_valid),
    .rob_redirect_pc      (32'h0000_0100),
    .lsu_busy             (1'b0),
    .fetch_redirect_ready (1'b1),
    .flush                (s_flush),
    .fetch_redirect_valid (s_fvalid),
    .fetch_redirect_pc    (s_fpc),
    .dispatch_stall       (s_stall),
    .state_o              (s_state),
    .redirect_cnt         (s_cnt),
    .overlap_err          (s_ovl),
    .drain_timeout_err    (s_tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and count the flush pulses seen after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (flush === 1'b1) flush_seen++;
  endtask

  initial begin
    // ---------------- 1: reset ----------------
    rst_aL               = 1'b0;
    s_rst_aL             = 1'b0;
    s_valid              = 1'b0;
    rob_redirect_valid   = 1'b1;
    rob_redirect_pc      = 32'hDEAD_BEEF;
    lsu_busy             = 1'b1;
    fetch_redirect_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_valid", 32'(fetch_redirect_valid), 32'd0);
    check("rst_pc",    fetch_redirect_pc, 32'd0);
    check("rst_stall", 32'(dispatch_stall), 32'd0);
    check("rst_cnt",   32'(redirect_cnt), 32'd0);
    check("rst_errs",  {30'd0, overlap_err, drain_timeout_err}, 32'd0);
    rob_redirect_valid = 1'b0;
    lsu_busy           = 1'b0;
    rst_aL             = 1'b1;
    s_rst_aL           = 1'b1;
    tick();
    check("idle_after_rst", 32'(state_o), 32'd0);

    // ---------------- 2: basic redirect ----------------
    flush_base         = flush_seen;
    rob_redirect_pc    = 32'h0000_1040;
    rob_redirect_valid = 1'b1;           // cycle T
    tick();                              // T+1
    rob_redirect_valid = 1'b0;
    check("b_flush_t1", 32'(flush), 32'd1);
    check("b_valid_t1", 32'(fetch_redirect_valid), 32'd0);
    check("b_stall_t1", 32'(dispatch_stall), 32'd1);
    check("b_cnt",      32'(redirect_cnt), 32'd1);
    tick();                              // T+2
    check("b_flush_t2", 32'(flush), 32'd0);
    check("b_valid_t2", 32'(fetch_redirect_valid), 32'd1);
    check("b_pc_t2",    fetch_redirect_pc, 32'h0000_1040);
    tick();                              // T+3
    check("b_state_t3", 32'(state_o), 32'd4);
    check("b_stall_t3", 32'(dispatch_stall), 32'd1);
    tick();                              // T+4
    check("b_stall_t4", 32'(dispatch_stall), 32'd1);
    tick();                              // T+5
    check("b_stall_t5", 32'(dispatch_stall), 32'd0);
    check("b_state_t5", 32'(state_o), 32'd0);
    check("b_one_flush", 32'(flush_seen - flush_base), 32'd1);

    // ---------------- 3: backpressure + drain ----------------
    fetch_redirect_ready = 1'b0;
    rob_redirect_pc      = 32'h3000_0008;
    rob_redirect_valid   = 1'b1;
    tick();                              // FLUSH
    rob_redirect_valid   = 1'b0;
    rob_redirect_pc      = 32'hFFFF_FFFF;
    tick();                              // REDIR, ready low
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(fetch_redirect_valid), 32'd1);
      check("bp_pc",    fetch_redirect_pc, 32'h3000_0008);
      if (i < 4) tick();
    end
    fetch_redirect_ready = 1'b1;
    lsu_busy             = 1'b1;
    tick();                              // DRAIN
    fetch_redirect_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("dr_state", 32'(state_o), 32'd3);
      tick();
    end
    check("dr_state_last", 32'(state_o), 32'd3);
    lsu_busy = 1'b0;
    tick();
    check("dr_exit_settle", 32'(state_o), 32'd4);
    check("dr_no_tmo",      32'(drain_timeout_err), 32'd0);
    tick(); tick();
    check("dr_idle", 32'(state_o), 32'd0);
    check("dr_cnt",  32'(redirect_cnt), 32'd2);

    // ---------------- 4: drain timeout ----------------
    fetch_redirect_ready = 1'b1;
    lsu_busy             = 1'b1;
    rob_redirect_pc      = 32'h0000_4000;
    rob_redirect_valid   = 1'b1;
    tick();                              // FLUSH
    rob_redirect_valid   = 1'b0;
    tick();                              // REDIR
    tick();                              // DRAIN entry
    drain_cyc = 0;
    while (state_o === 3'd3 && drain_cyc < 200) begin
      drain_cyc++;
      tick();
    end
    check("to_cycles",  32'(drain_cyc), 32'd64);
    check("to_settle",  32'(state_o), 32'd4);
    check("to_err",     32'(drain_timeout_err), 32'd1);
    lsu_busy = 1'b0;
    tick(); tick();
    check("to_idle", 32'(state_o), 32'd0);
    check("to_cnt",  32'(redirect_cnt), 32'd3);

    // ---------------- 5: overlap ----------------
    flush_base           = flush_seen;
    fetch_redirect_ready = 1'b0;
    rob_redirect_pc      = 32'h0000_1040;
    rob_redirect_valid   = 1'b1;
    tick();                              // FLUSH
    rob_redirect_valid   = 1'b0;
    check("ov_no_err_yet", 32'(overlap_err), 32'd0);
    tick();                              // REDIR
    rob_redirect_pc      = 32'h0000_2000;
    rob_redirect_valid   = 1'b1;
    tick();                              // still REDIR, pulse ignored
    rob_redirect_valid   = 1'b0;
    check("ov_state", 32'(state_o), 32'd2);
    check("ov_pc",    fetch_redirect_pc, 32'h0000_1040);
    check("ov_cnt",   32'(redirect_cnt), 32'd4);
    check("ov_err",   32'(overlap_err), 32'd1);
    fetch_redirect_ready = 1'b1;
    tick();                              // SETTLE 1
    fetch_redirect_ready = 1'b0;
    tick();                              // SETTLE 2 (last)
    check("ov_settle_last", 32'(state_o), 32'd4);
    rob_redirect_valid = 1'b1;           // pulse on the SETTLE->IDLE edge
    tick();
    rob_redirect_valid = 1'b0;
    check("ov_edge_idle", 32'(state_o), 32'd0);
    check("ov_edge_cnt",  32'(redirect_cnt), 32'd4);
    tick();
    check("ov_edge_stay", 32'(state_o), 32'd0);
    check("ov_one_flush", 32'(flush_seen - flush_base), 32'd1);

    // ---------------- 6: reset mid-DRAIN ----------------
    fetch_redirect_ready = 1'b1;
    lsu_busy             = 1'b1;
    rob_redirect_pc      = 32'h0000_5000;
    rob_redirect_valid   = 1'b1;
    tick();                              // FLUSH
    rob_redirect_valid   = 1'b0;
    tick();                              // REDIR
    tick();                              // DRAIN
    tick();
    check("mr_in_drain", 32'(state_o), 32'd3);
    rst_aL = 1'b0;
    #1;
    check("mr_state", 32'(state_o), 32'd0);
    check("mr_stall", 32'(dispatch_stall), 32'd0);
    check("mr_cnt",   32'(redirect_cnt), 32'd0);
    check("mr_errs",  {30'd0, overlap_err, drain_timeout_err}, 32'd0);
    flush_base = flush_seen;
    tick();
    rst_aL   = 1'b1;
    lsu_busy = 1'b0;
    tick(); tick();
    check("mr_idle",     32'(state_o), 32'd0);
    check("mr_no_flush", 32'(flush_seen - flush_base), 32'd0);

    // ---------------- 6b: saturation, CNT_WIDTH=2 ----------------
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      tick();                            // FLUSH
      s_valid = 1'b0;
      tick(); tick(); tick(); tick();    // REDIR, SETTLE, SETTLE, IDLE
      check("sat_idle", 32'(s_state), 32'd0);
      check("sat_cnt",  32'(s_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
